ahb_rr_burst_arb: RTL and testbench
===================================

Name: ahb_rr_burst_arb

Overview:
- Output-stage arbiter for one shared AHB slave port in the L1 bus matrix.
- Selects which of four input ports drives the slave using round-robin priority.
- Never re-arbitrates inside a locked sequence, a fixed-length burst or an active undefined-length INCR burst.
- Drop-in alternative to the fixed-priority output arbiter. Feeds the output-stage address/data muxes.

Parameters:
- NUM_PORTS, 4, number of requesting input ports (design and verification fixed at 4)
- PORT_W, 2, width of the port index

Ports:
- HCLK  input  1  AHB system clock
- HRESET  input  1  asynchronous, active-high reset
- req_port  input  4  per-port request from the input stages; bit k = port k
- HREADYM  input  1  transfer done on the shared slave
- HSELM  input  1  slave select of the currently driven address phase
- HTRANSM  input  2  transfer type of the current address phase
- HBURSTM  input  3  burst type of the current address phase
- HMASTLOCKM  input  1  locked transfer
- addr_in_port  output  2  index of the selected input port
- no_port  output  1  no input port selected
- burst_hold  output  1  registered; arbitration frozen by a burst or lock

Behaviour:
- Reset (HRESET high, async): addr_in_port=0, no_port=1, burst_hold=0, beat_cnt=0, last_grant=3, so port 0 has top priority first.
- All state updates occur only on a posedge HCLK with HREADYM=1. With HREADYM=0, every register holds.
- accepted = HREADYM & HSELM & HTRANSM[1] (NONSEQ or SEQ).
- beat_cnt_next (4-bit):
  - Accepted NONSEQ: load 3 for INCR4/WRAP4 (HBURSTM=3'b010/011), 7 for 8-beat (3'b100/101), 15 for 16-beat (3'b110/111), 0 for SINGLE/INCR.
  - Accepted SEQ with beat_cnt>0: decrement.
  - BUSY (HTRANSM=2'b01) with HSELM: hold the count.
  - IDLE, or HSELM=0: clear to 0 (early burst termination).
- hold = HMASTLOCKM | (beat_cnt_next != 0) | (HSELM & HBURSTM==3'b001 & HTRANSM != 2'b00).
- Next-state selection, in priority order:
  - If hold: addr_in_port and no_port unchanged; burst_hold<=1.
  - Else if any req_port bit is set: grant the first set bit scanning last_grant+1, +2, +3, +4 (mod 4). addr_in_port<=winner, last_grant<=winner, no_port<=0, burst_hold<=0.
  - Else if HSELM: keep the current port (it is running IDLEs to this slave); no_port unchanged; burst_hold<=0.
  - Else: no_port<=1, addr_in_port unchanged, burst_hold<=0.
- Re-granting the current port when it alone requests is legal; last_grant is still updated.
- A request from a port that is not selected never affects addr_in_port while hold=1.
- Latency: a grant decided in cycle N (HREADYM=1) is visible on addr_in_port after posedge N+1.
- Combinational path is inputs to next-state only. Outputs are registered; no input-to-output combinational path.
- Wrap-around: the scan index wraps 3 to 0. last_grant=3 scans 0,1,2,3.
- Mid-operation reset: all state returns immediately to reset values, including any frozen burst.

Test Plan:
- After reset, req_port=4'b1111, HSELM=0, HREADYM=1 every cycle, request held: addr_in_port cycles 0,1,2,3,0. no_port=0 from the first grant onward.
- Port 1 granted; it issues NONSEQ INCR4 then 3 SEQ with HSELM=1, while req_port=4'b0101. addr_in_port stays 1 and burst_hold=1 through the last SEQ acceptance. On the next HREADYM, port 2 is granted.
- INCR8 from port 0 with HREADYM=0 for 3 cycles mid-burst plus one BUSY beat: beat_cnt holds through both and the grant never changes. The hold releases only after 8 accepted beats.
- Fixed burst terminated by IDLE after 2 beats, req_port=4'b1000: beat_cnt clears and port 3 is granted on that HREADYM.
- HMASTLOCKM=1 with port 2 selected, req_port=4'b0011 for 5 cycles: addr_in_port stays 2. On the first HREADYM with lock low, port 3 is skipped (not requesting) and port 0 is granted.
- req_port=0 and HSELM=0: no_port=1 after one clock. Assert HRESET mid-INCR16: addr_in_port=0, no_port=1, burst_hold=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ahb_rr_burst_arb_if.sv
// Purpose: bundles the request vector, shared-slave AHB address-phase controls
//          and the registered grant outputs of the round-robin output arbiter.
// Ports:   master = input-stage/bus side (drives requests and AHB controls),
//          slave  = arbiter side (drives addr_in_port, no_port, burst_hold).
interface ahb_rr_burst_arb_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
);
    logic [NUM_PORTS-1:0] req_port;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PORT_W-1:0]    addr_in_port;
    logic                 no_port;
    logic                 burst_hold;

    modport master (
        output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port, burst_hold
    );

    modport slave (
        input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port, burst_hold
    );
endinterface

// File: rtl/ahb_rr_burst_arb.sv
// Purpose:      round-robin arbiter choosing which of four input ports drives one shared AHB slave.
// Latency:      grant decided in a HREADYM=1 cycle appears on addr_in_port after that clock edge.
// Backpressure: HREADYM=0 freezes every register; bursts and locked sequences freeze the grant.
// Ports: HCLK, HRESET (async, active high); bus (slave modport): req_port, HREADYM, HSELM,
//        HTRANSM, HBURSTM, HMASTLOCKM in; addr_in_port, no_port, burst_hold out (all registered).
module ahb_rr_burst_arb #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_rr_burst_arb_if.slave    bus
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BURST_INCR = 3'b001;

    logic [PORT_W-1:0] port_q;
    logic              no_port_q;
    logic              hold_q;
    logic [3:0]        beat_cnt;
    logic [PORT_W-1:0] last_grant;

    logic [3:0]        beat_cnt_next;
    logic              hold;
    logic              rr_found;
    logic [PORT_W-1:0] rr_winner;
    logic [PORT_W-1:0] rr_idx;

    assign bus.addr_in_port = port_q;
    assign bus.no_port      = no_port_q;
    assign bus.burst_hold   = hold_q;

    // Remaining beats of a fixed-length burst. Only evaluated into state when
    // HREADYM=1, so every NONSEQ/SEQ seen here counts as an accepted beat.
    // Deselect or IDLE abandons whatever burst was in flight.
    always_comb begin
        beat_cnt_next = '0;
        if (bus.HSELM) begin
            unique case (bus.HTRANSM)
                TR_NONSEQ: begin
                    unique case (bus.HBURSTM)
                        3'b010, 3'b011: beat_cnt_next = 4'd3;
                        3'b100, 3'b101: beat_cnt_next = 4'd7;
                        3'b110, 3'b111: beat_cnt_next = 4'd15;
                        default:        beat_cnt_next = 4'd0;
                    endcase
                end
                TR_SEQ: begin
                    if (beat_cnt != 4'd0)
                        beat_cnt_next = beat_cnt - 4'd1;
                end
                TR_BUSY: beat_cnt_next = beat_cnt;
                TR_IDLE: beat_cnt_next = 4'd0;
            endcase
        end
    end

    // Freeze arbitration for locks, unfinished fixed bursts, and any non-IDLE
    // beat of an undefined-length INCR burst (its end is only known at IDLE).
    assign hold = bus.HMASTLOCKM
                | (beat_cnt_next != 4'd0)
                | (bus.HSELM & (bus.HBURSTM == BURST_INCR) & (bus.HTRANSM != TR_IDLE));

    // Scan last_grant+1 .. last_grant+NUM_PORTS; PORT_W-bit addition gives the
    // modulo wrap for free because NUM_PORTS is a power of two.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = last_grant;
        rr_idx    = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            rr_idx = last_grant + PORT_W'(i);
            if (!rr_found && bus.req_port[rr_idx]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            port_q     <= '0;
            no_port_q  <= 1'b1;
            hold_q     <= 1'b0;
            beat_cnt   <= 4'd0;
            last_grant <= PORT_W'(NUM_PORTS - 1);
        end else if (bus.HREADYM) begin
            beat_cnt <= beat_cnt_next;
            if (hold) begin
                hold_q <= 1'b1;
            end else if (rr_found) begin
                port_q     <= rr_winner;
                last_grant <= rr_winner;
                no_port_q  <= 1'b0;
                hold_q     <= 1'b0;
            end else if (bus.HSELM) begin
                // Current owner is still addressing this slave with IDLEs.
                hold_q <= 1'b0;
            end else begin
                no_port_q <= 1'b1;
                hold_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_rr_burst_arb.sv
// Purpose: self-checking bench for ahb_rr_burst_arb; expected grant outputs are
//          queued as each cycle of stimulus is driven and compared after the edge.
module tb_ahb_rr_burst_arb;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_INCR8  = 3'b101;
    localparam logic [2:0] B_INCR16 = 3'b111;

    typedef struct {
        logic [1:0] port;
        logic       no;
        logic       hold;
    } exp_t;

    logic HCLK;
    logic HRESET;
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    exp_t sb_q[$];

    ahb_rr_burst_arb_if #(.NUM_PORTS(4), .PORT_W(2)) bus ();

    ahb_rr_burst_arb #(.NUM_PORTS(4), .PORT_W(2)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.slave)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        cmp_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // One bus cycle: drive inputs, queue the expected post-edge outputs,
    // clock, then pop and compare.
    task automatic step(input string tag, input logic [3:0] req, input logic rdy,
                        input logic sel, input logic [1:0] trans, input logic [2:0] burst,
                        input logic lock, input logic [1:0] e_port, input logic e_no,
                        input logic e_hold);
        exp_t e;
        exp_t g;
        bus.req_port   = req;
        bus.HREADYM    = rdy;
        bus.HSELM      = sel;
        bus.HTRANSM    = trans;
        bus.HBURSTM    = burst;
        bus.HMASTLOCKM = lock;
        e.port = e_port;
        e.no   = e_no;
        e.hold = e_hold;
        sb_q.push_back(e);
        @(posedge HCLK);
        #1;
        chk({tag, ".sbq"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            g = sb_q.pop_front();
            chk({tag, ".port"}, 32'(bus.addr_in_port), 32'(g.port));
            chk({tag, ".no"},   32'(bus.no_port),      32'(g.no));
            chk({tag, ".hold"}, 32'(bus.burst_hold),   32'(g.hold));
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        HRESET         = 1'b1;
        bus.req_port   = 4'b0000;
        bus.HREADYM    = 1'b1;
        bus.HSELM      = 1'b0;
        bus.HTRANSM    = T_IDLE;
        bus.HBURSTM    = B_SINGLE;
        bus.HMASTLOCKM = 1'b0;
        #12;
        chk("rst.port", 32'(bus.addr_in_port), 32'd0);
        chk("rst.no",   32'(bus.no_port),      32'd1);
        chk("rst.hold", 32'(bus.burst_hold),   32'd0);
        HRESET = 1'b0;

        // Round robin with all ports requesting: 0,1,2,3,0.
        step("rr0", 4'b1111, 1, 0, T_IDLE, B_SINGLE, 0, 2'd0, 0, 0);
        step("rr1", 4'b1111, 1, 0, T_IDLE, B_SINGLE, 0, 2'd1, 0, 0);
        step("rr2", 4'b1111, 1, 0, T_IDLE, B_SINGLE, 0, 2'd2, 0, 0);
        step("rr3", 4'b1111, 1, 0, T_IDLE, B_SINGLE, 0, 2'd3, 0, 0);
        step("rr4", 4'b1111, 1, 0, T_IDLE, B_SINGLE, 0, 2'd0, 0, 0);

        // INCR4 from port 1; ports 0 and 2 wait, port 2 wins at the last SEQ.
        step("g1",    4'b0010, 1, 0, T_IDLE, B_SINGLE, 0, 2'd1, 0, 0);
        step("b4_ns", 4'b0101, 1, 1, T_NSEQ, B_INCR4,  0, 2'd1, 0, 1);
        step("b4_s1", 4'b0101, 1, 1, T_SEQ,  B_INCR4,  0, 2'd1, 0, 1);
        step("b4_s2", 4'b0101, 1, 1, T_SEQ,  B_INCR4,  0, 2'd1, 0, 1);
        step("b4_s3", 4'b0101, 1, 1, T_SEQ,  B_INCR4,  0, 2'd2, 0, 0);

        // INCR8 from port 0 with wait states and a BUSY beat.
        step("g0",    4'b0001, 1, 0, T_IDLE, B_SINGLE, 0, 2'd0, 0, 0);
        step("b8_ns", 4'b1110, 1, 1, T_NSEQ, B_INCR8,  0, 2'd0, 0, 1);
        step("b8_s",  4'b1110, 1, 1, T_SEQ,  B_INCR8,  0, 2'd0, 0, 1);
        for (int i = 0; i < 3; i++)
            step("b8_wait", 4'b1110, 0, 1, T_SEQ, B_INCR8, 0, 2'd0, 0, 1);
        step("b8_busy", 4'b1110, 1, 1, T_BUSY, B_INCR8, 0, 2'd0, 0, 1);
        for (int i = 0; i < 5; i++)
            step("b8_sn", 4'b1110, 1, 1, T_SEQ, B_INCR8, 0, 2'd0, 0, 1);
        step("b8_last", 4'b1110, 1, 1, T_SEQ, B_INCR8, 0, 2'd1, 0, 0);

        // Fixed burst cut short by IDLE after two beats.
        step("t_ns",   4'b1000, 1, 1, T_NSEQ, B_INCR4, 0, 2'd1, 0, 1);
        step("t_s",    4'b1000, 1, 1, T_SEQ,  B_INCR4, 0, 2'd1, 0, 1);
        step("t_idle", 4'b1000, 1, 1, T_IDLE, B_INCR4, 0, 2'd3, 0, 0);

        // Locked sequence on port 2; release skips idle port 3 and picks 0.
        step("l_g2", 4'b0100, 1, 0, T_IDLE, B_SINGLE, 0, 2'd2, 0, 0);
        for (int i = 0; i < 5; i++)
            step("l_lock", 4'b0011, 1, 1, T_NSEQ, B_SINGLE, 1, 2'd2, 0, 1);
        step("l_rel", 4'b0011, 1, 1, T_IDLE, B_SINGLE, 0, 2'd0, 0, 0);

        // No requests but slave still selected: keep current port.
        step("keep", 4'b0000, 1, 1, T_IDLE, B_SINGLE, 0, 2'd0, 0, 0);

        // Undefined-length INCR holds until IDLE.
        step("i_g2",   4'b0100, 1, 0, T_IDLE, B_SINGLE, 0, 2'd2, 0, 0);
        step("i_ns",   4'b1011, 1, 1, T_NSEQ, B_INCR,   0, 2'd2, 0, 1);
        step("i_s",    4'b1011, 1, 1, T_SEQ,  B_INCR,   0, 2'd2, 0, 1);
        step("i_busy", 4'b1011, 1, 1, T_BUSY, B_INCR,   0, 2'd2, 0, 1);
        step("i_end",  4'b1011, 1, 1, T_IDLE, B_INCR,   0, 2'd3, 0, 0);

        // Nothing requested, nothing selected.
        step("none",  4'b0000, 1, 0, T_IDLE, B_SINGLE, 0, 2'd3, 1, 0);
        // Lone requester re-granted, then wrap from 3 to 0.
        step("solo",  4'b1000, 1, 0, T_IDLE, B_SINGLE, 0, 2'd3, 0, 0);
        step("wrap",  4'b1001, 1, 0, T_IDLE, B_SINGLE, 0, 2'd0, 0, 0);

        // Asynchronous reset in the middle of an INCR16.
        step("r_g1", 4'b0010, 1, 0, T_IDLE, B_SINGLE, 0, 2'd1, 0, 0);
        step("r_ns", 4'b0010, 1, 1, T_NSEQ, B_INCR16, 0, 2'd1, 0, 1);
        step("r_s",  4'b0010, 1, 1, T_SEQ,  B_INCR16, 0, 2'd1, 0, 1);
        #2;
        HRESET = 1'b1;
        #1;
        chk("arst.port", 32'(bus.addr_in_port), 32'd0);
        chk("arst.no",   32'(bus.no_port),      32'd1);
        chk("arst.hold", 32'(bus.burst_hold),   32'd0);
        #2;
        HRESET = 1'b0;
        // A stray SEQ must not resurrect the burst; priority restarts at port 0.
        step("post",  4'b1111, 1, 1, T_SEQ,  B_INCR16, 0, 2'd0, 0, 0);
        step("post2", 4'b1111, 1, 0, T_IDLE, B_SINGLE, 0, 2'd1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
